// File: rtl/maze_scene_renderer.sv
// maze_scene_renderer: streams maze walls and food for a full frame or one tile, one pixel byte per TFT handshake
module maze_scene_renderer #(
  parameter int GRID_W = 10,
  parameter int GRID_H = 15,
  parameter int TILE_LOG2 = 5,
  parameter int WALL_W = 4,
  parameter int FOOD_W = 8,
  parameter int BPP = 3,
  parameter logic [7:0] WALL_R = 8'h3a,
  parameter logic [7:0] WALL_G = 8'h7b,
  parameter logic [7:0] WALL_B = 8'hd5,
  localparam int TXW = GRID_W > 1 ? $clog2(GRID_W) : 1,
  localparam int TYW = GRID_H > 1 ? $clog2(GRID_H) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               tile_mode,
  input  logic [TXW-1:0]                     tile_x,
  input  logic [TYW-1:0]                     tile_y,
  input  logic [GRID_H*(GRID_W+1)-1:0]       v_walls,
  input  logic [(GRID_H+1)*GRID_W-1:0]       h_walls,
  input  logic [2*GRID_W*GRID_H-1:0]         food,
  input  logic                               tft_busy,
  output logic                               tft_dc,
  output logic [7:0]                         tft_data,
  output logic                               tft_transmit,
  output logic                               busy,
  output logic                               done
);
  localparam int T = 1 << TILE_LOG2;
  localparam int XW = $clog2(GRID_W * T);
  localparam int YW = $clog2(GRID_H * T);
  localparam int CW = BPP > 1 ? $clog2(BPP) : 1;
  typedef enum logic [1:0] {IDLE, EMIT, GAP, DONE} state_t;
  state_t state;
  logic [XW-1:0] x, x0, x1;
  logic [YW-1:0] y, y1;
  logic [CW-1:0] ch;
  logic [7:0] pix, base, g;
  logic [1:0] ft;
  logic vl, vr, ht, hb, fd, wall, last;
  int xi, yi, ci, tc, tr, lx, ly;
  assign tft_dc = 1'b1;
  always_comb begin
    xi = int'(x);
    yi = int'(y);
    ci = int'(ch);
    tc = xi >> TILE_LOG2;
    tr = yi >> TILE_LOG2;
    lx = xi % T;
    ly = yi % T;
    vl = 1'(v_walls >> (tr * (GRID_W + 1) + tc));
    vr = 1'(v_walls >> (tr * (GRID_W + 1) + tc + 1));
    ht = 1'(h_walls >> (tr * GRID_W + tc));
    hb = 1'(h_walls >> ((tr + 1) * GRID_W + tc));
    ft = 2'(food >> (2 * (tr * GRID_W + tc)));
    fd = ft != 2'd0 && lx >= T/2 - FOOD_W/2 && lx < T/2 + FOOD_W/2
                    && ly >= T/2 - FOOD_W/2 && ly < T/2 + FOOD_W/2;
    wall = (lx < WALL_W && vl) || (lx >= T - WALL_W && vr)
        || (ly < WALL_W && ht) || (ly >= T - WALL_W && hb);
    g = 8'((2 * xi + 3 * yi) >> 5);
    base = ci == 0 ? WALL_R : ci == 1 ? WALL_G : ci == 2 ? WALL_B : 8'h00;
    pix = fd ? (ci == int'(ft) - 1 ? 8'hff : 8'h00) : wall ? (ci < 2 ? base + g : base) : 8'h00;
    last = ci == BPP - 1 && x == x1 && y == y1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      x <= '0;
      x0 <= '0;
      x1 <= '0;
      y <= '0;
      y1 <= '0;
      ch <= '0;
      tft_data <= 8'h00;
      tft_transmit <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (tile_mode && (int'(tile_x) >= GRID_W || int'(tile_y) >= GRID_H)) begin
            state <= DONE;
            done <= 1'b1;
          end else begin
            x0 <= XW'(tile_mode ? int'(tile_x) * T : 0);
            x <= XW'(tile_mode ? int'(tile_x) * T : 0);
            y <= YW'(tile_mode ? int'(tile_y) * T : 0);
            x1 <= XW'(tile_mode ? int'(tile_x) * T + T - 1 : GRID_W * T - 1);
            y1 <= YW'(tile_mode ? int'(tile_y) * T + T - 1 : GRID_H * T - 1);
            ch <= '0;
            busy <= 1'b1;
            state <= EMIT;
          end
        end
        EMIT: if (!tft_busy) begin
          tft_data <= pix;
          tft_transmit <= 1'b1;
          state <= GAP;
        end
        GAP: begin
          tft_transmit <= 1'b0;
          if (ch == CW'(BPP - 1)) begin
            ch <= '0;
            x <= x == x1 ? x0 : x + 1'b1;
            y <= x == x1 ? y + 1'b1 : y;
          end else begin
            ch <= ch + 1'b1;
          end
          state <= last ? DONE : EMIT;
          done <= last;
          busy <= !last;
        end
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/maze_scene_renderer.md
Name: maze_scene_renderer

Overview:
- Parametrised successor of the fixed 10x15 scene painter; streams maze walls and food to the TFT data path, one pixel byte per handshake.
- Generalises grid size, tile size, wall thickness, food size and bytes-per-pixel.
- Adds a start/done handshake and a single-tile redraw mode, so the game loop can repaint only changed tiles after tft_init finishes.

Parameters:
GRID_W, 10, tiles per row
GRID_H, 15, tiles per column
TILE_LOG2, 5, tile edge T = 2**TILE_LOG2 pixels
WALL_W, 4, wall thickness in pixels from a tile edge (1..T/2)
FOOD_W, 8, edge of the centred food square in pixels (even, <= T)
BPP, 3, bytes per pixel, channel order 0..BPP-1 (R,G,B for 3)
WALL_R / WALL_G / WALL_B, 8'h3a / 8'h7b / 8'hd5, base wall colour per channel

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request; ignored unless idle
tile_mode  in  1  0 = full frame, 1 = single tile; sampled with start
tile_x  in  max(1,$clog2(GRID_W))  tile column; sampled with start
tile_y  in  max(1,$clog2(GRID_H))  tile row; sampled with start
v_walls  in  GRID_H*(GRID_W+1)  bit r*(GRID_W+1)+c = vertical wall on the left edge of column c in row r (c=GRID_W is the right border)
h_walls  in  (GRID_H+1)*GRID_W  bit r*GRID_W+c = horizontal wall on the top edge of row r in column c (r=GRID_H is the bottom border)
food  in  2*GRID_W*GRID_H  bits [2i+1:2i], i=r*GRID_W+c: 0 none, 1 red, 2 green, 3 blue
tft_busy  in  1  TFT serialiser busy
tft_dc  out  1  constant 1 (data)
tft_data  out  8  byte to send
tft_transmit  out  1  one-cycle send strobe
busy  out  1  job in progress
done  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: state IDLE; tft_data=0, tft_transmit=0, busy=0, done=0; pixel and channel counters 0.
- Inputs v_walls, h_walls and food are read live; the caller holds them stable while busy.
- Region, full frame: x=0..GRID_W*T-1, y=0..GRID_H*T-1.
- Region, tile mode: x=tile_x*T..+T-1, y=tile_y*T..+T-1.
- Order: raster, y outer, x inner; for each pixel, channels 0..BPP-1.
- Pixel decode: tc=x>>TILE_LOG2, tr=y>>TILE_LOG2, lx=x mod T, ly=y mod T.
- Priority: food, then wall, then background 0.
- Food: lx and ly both in [T/2-FOOD_W/2, T/2+FOOD_W/2) and type != 0. Byte is 8'hff on channel type-1, else 8'h00; channels >= 3 are 0.
- Wall: any of
  - lx<WALL_W and v_walls[tr*(GRID_W+1)+tc]
  - lx>=T-WALL_W and v_walls[tr*(GRID_W+1)+tc+1]
  - ly<WALL_W and h_walls[tr*GRID_W+tc]
  - ly>=T-WALL_W and h_walls[(tr+1)*GRID_W+tc]
- Wall byte: base[ch] + g, mod 256, where g=((2x+3y)>>5)[7:0]. g is applied to channels 0 and 1 only; channel 2 gets base unshifted. Channels >= 3 are 0.
- FSM, IDLE:
  - busy=0.
  - On start: latch mode and tile, load the region origin, then go to EMIT.
  - If tile_mode=1 and (tile_x>=GRID_W or tile_y>=GRID_H): go straight to DONE, no bytes sent.
- FSM, EMIT: busy=1. When tft_busy=0, drive tft_data with the current byte and tft_transmit=1 for this cycle only, then go to GAP. Otherwise hold.
- FSM, GAP:
  - tft_transmit=0.
  - Advance: channel; on wrap x; on x wrap y.
  - If the byte just sent was the last of the region, go to DONE, else EMIT.
  - Minimum strobe spacing is therefore 2 cycles.
- FSM, DONE: done=1 for one cycle, busy=0, then IDLE.
- tft_data holds its last value between strobes.
- start while not IDLE is ignored, and start in the DONE cycle is ignored.
- Byte counts per job: full frame GRID_W*GRID_H*T*T*BPP; tile T*T*BPP.
- Reset mid-job: all outputs return to reset values immediately; no done pulse; the interrupted job is dropped.

Test Plan:
- Reset, then GRID_W=2, GRID_H=2, TILE_LOG2=2, WALL_W=1, FOOD_W=2, BPP=3, all inputs 0, start full frame, tft_busy=0 -> exactly 192 strobes, all bytes 0, strobes 2 cycles apart, done pulses once, busy low after.
- Same config, food[1:0]=2 (tile 0,0 green) -> pixels (1,1),(2,1),(1,2),(2,2) emit 00,ff,00; all other bytes 0.
- Defaults, v_walls bit 0 set, tile mode tile (0,0) -> 3072 strobes. Pixel (x=3,y=20) emits 3c,7d,d5 (g=2). Pixel (x=4,y=20) emits 00,00,00.
- Hold tft_busy=1 for 10 cycles mid-frame -> no strobe while busy; the pending byte is sent on the first cycle tft_busy=0; no bytes lost or duplicated (compare against a golden count).
- Defaults, tile_mode=1, tile_x=12 -> no strobes; done pulses the cycle after the DONE transition; extra start pulses while busy produce no second job.
- Assert rst after 50 bytes of a job -> tft_transmit, busy and done read 0 asynchronously; a new start then replays from byte 0.
